sd_sector_responder: RTL and testbench

//  Responder (card side) of the sd_controller byte-stream interface (rd/wr/address/ready/byte_available/ready_for_next_byte).

---
 rtl/sd_pkg.sv | 17 +
 rtl/sd_resp_mem.sv | 23 ++
 rtl/sd_sector_responder.sv | 163 ++++++++++++++++
 tb/tb_sd_sector_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types for the cardless SD sector responder.
package sd_pkg;

  localparam int DEFAULT_SECTOR_SIZE = 512;

  // Explicit encodings so the state codes stay stable across builds.
  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    RD_LAT  = 3'd2,
    RD_BYTE = 3'd3,
    WR_LAT  = 3'd4,
    WR_BYTE = 3'd5,
    DONE    = 3'd6
  } sd_state_e;

endpackage

// File: rtl/sd_resp_mem.sv
// Single-port byte RAM backing the responder's sectors.
// Synchronous read (one-cycle latency) and no reset, so the stored data
// survives a responder reset.
module sd_resp_mem #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write-enable port plus registered read of the same address.
  always_ff @(posedge clk_in) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sd_sector_responder.sv
// Card-side stand-in for the sd_controller byte-stream interface.
// Stores NUM_SECTORS x SECTOR_SIZE bytes on chip and reproduces the
// controller's pacing: init delay, command latency and fixed byte slots.
// Optional build macro SD_RESP_STATS_EN adds per-direction counters of
// completed in-range sectors (rd_sectors_out / wr_sectors_out).
module sd_sector_responder
  import sd_pkg::*;
#(
  parameter int SECTOR_SIZE = DEFAULT_SECTOR_SIZE,
  parameter int NUM_SECTORS = 8,
  parameter int INIT_CYCLES = 64,
  parameter int CMD_LATENCY = 16,
  parameter int BYTE_GAP    = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [7:0]  din,
  output logic        ready,
  output logic [7:0]  dout,
  output logic        byte_available,
  output logic        ready_for_next_byte,
  output logic        err_out
`ifdef SD_RESP_STATS_EN
  ,
  output logic [15:0] rd_sectors_out,
  output logic [15:0] wr_sectors_out
`endif
);

  localparam int SB      = $clog2(SECTOR_SIZE);
  localparam int NB      = $clog2(NUM_SECTORS);
  localparam int AW      = NB + SB;
  localparam int SECW    = 32 - SB;
  localparam int CNT_MAX = (INIT_CYCLES > CMD_LATENCY) ? INIT_CYCLES : CMD_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int GW      = $clog2(BYTE_GAP);

  sd_state_e       state;
  logic [CW-1:0]   cnt;       // init / command latency counter
  logic [GW-1:0]   slot;      // cycle within the current byte slot
  logic [SB-1:0]   byte_idx;
  logic [NB-1:0]   sector;
  logic            oor;       // latched: current transfer is out of range
  logic            req_oor;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_rdata;
  logic            mem_we;
  logic            slot_last;
  logic            byte_last;
  logic            unused_addr_lsb;

  // Byte offset within the sector is not used by a sector-granular device.
  assign unused_addr_lsb = ^address[SB-1:0];

  assign req_oor   = address[31:SB] >= SECW'(NUM_SECTORS);
  assign slot_last = slot == GW'(BYTE_GAP - 1);
  assign byte_last = byte_idx == SB'(SECTOR_SIZE - 1);

  assign ready               = state == IDLE;
  assign byte_available      = (state == RD_BYTE) && (slot < GW'(2));
  assign ready_for_next_byte = (state == WR_BYTE) && (slot <= GW'(BYTE_GAP - 3));

  // RAM address: writes target the current byte; reads prefetch the next
  // byte during the slot so it is ready to load into dout at the boundary.
  always_comb begin
    mem_addr = {sector, SB'(0)};
    if (state == WR_BYTE)      mem_addr = {sector, byte_idx};
    else if (state == RD_BYTE) mem_addr = {sector, byte_idx + SB'(1)};
  end

  // din is captured on the last cycle of the write slot; out-of-range writes are dropped.
  assign mem_we = (state == WR_BYTE) && slot_last && !oor;

  sd_resp_mem #(
    .DEPTH (NUM_SECTORS * SECTOR_SIZE),
    .AW    (AW)
  ) u_mem (
    .clk_in (clk_in),
    .we     (mem_we),
    .addr   (mem_addr),
    .wdata  (din),
    .rdata  (mem_rdata)
  );

  // Main FSM with slot/byte/latency counters, read data register and sticky error.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= INIT;
      cnt      <= '0;
      slot     <= '0;
      byte_idx <= '0;
      sector   <= '0;
      oor      <= 1'b0;
      dout     <= 8'h00;
      err_out  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == CW'(INIT_CYCLES - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (rd || wr) begin
            state  <= rd ? RD_LAT : WR_LAT;
            sector <= address[SB +: NB];
            oor    <= req_oor;
            cnt    <= '0;
            if (req_oor) err_out <= 1'b1;
          end
        end
        RD_LAT, WR_LAT: begin
          if (cnt == CW'(CMD_LATENCY - 1)) begin
            state    <= (state == RD_LAT) ? RD_BYTE : WR_BYTE;
            slot     <= '0;
            byte_idx <= '0;
            // Byte 0 has been on the RAM output since early in the latency wait.
            if (state == RD_LAT) dout <= oor ? 8'hFF : mem_rdata;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_BYTE, WR_BYTE: begin
          if (slot_last) begin
            slot <= '0;
            if (byte_last) begin
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              if (state == RD_BYTE) dout <= oor ? 8'hFF : mem_rdata;
            end
          end else begin
            slot <= slot + 1'b1;
          end
        end
        DONE: begin
          if (!rd && !wr) state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef SD_RESP_STATS_EN
  // Count in-range sectors as they complete (entry to DONE); free-running wrap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_sectors_out <= 16'h0000;
      wr_sectors_out <= 16'h0000;
    end else if (slot_last && byte_last && !oor) begin
      if (state == RD_BYTE) rd_sectors_out <= rd_sectors_out + 16'h0001;
      if (state == WR_BYTE) wr_sectors_out <= wr_sectors_out + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench for sd_sector_responder: the stimulus side pushes the
// bytes a read must return (from a plain array model of the sectors) and
// a separate monitor pops and compares them on each byte_available strobe.
module tb_sd_sector_responder;

  localparam int SS   = 512;
  localparam int NS   = 8;
  localparam int INIT = 64;
  localparam int LAT  = 16;
  localparam int GAP  = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] address = 32'h0;
  logic [7:0]  din = 8'h00;
  logic        ready;
  logic [7:0]  dout;
  logic        byte_available;
  logic        ready_for_next_byte;
  logic        err_out;
`ifdef SD_RESP_STATS_EN
  logic [15:0] rd_sectors_out;
  logic [15:0] wr_sectors_out;
`endif

  int checks = 0;
  int errors = 0;

  always #20 clk_in = ~clk_in;

  sd_sector_responder #(
    .SECTOR_SIZE (SS),
    .NUM_SECTORS (NS),
    .INIT_CYCLES (INIT),
    .CMD_LATENCY (LAT),
    .BYTE_GAP    (GAP)
  ) dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .rd                  (rd),
    .wr                  (wr),
    .address             (address),
    .din                 (din),
    .ready               (ready),
    .dout                (dout),
    .byte_available      (byte_available),
    .ready_for_next_byte (ready_for_next_byte),
    .err_out             (err_out)
`ifdef SD_RESP_STATS_EN
    ,
    .rd_sectors_out      (rd_sectors_out),
    .wr_sectors_out      (wr_sectors_out)
`endif
  );

  // Reference model: sector contents and sticky error flag.
  logic [7:0] ram_m [NS*SS];
  logic       err_m = 1'b0;
  logic [7:0] wbuf  [SS];
  logic [7:0] exp_q [$];
  int         rx_cnt = 0;
  int         rfnb_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: byte strobes, slot-long dout stability and strobe widths.
  logic       ba_q = 1'b0, rf_q = 1'b0, in_slot = 1'b0;
  int         ba_hi = 0, rf_hi = 0, pos = 0;
  logic [7:0] cur_exp = 8'h00;

  initial forever begin
    @(negedge clk_in);
    if (!rst_n_in) begin
      ba_q = 1'b0; rf_q = 1'b0; in_slot = 1'b0; ba_hi = 0; rf_hi = 0;
    end else begin
      if (byte_available && !ba_q) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          fail("ba_unexpected", "byte strobe with nothing expected");
          in_slot = 1'b0;
        end else begin
          cur_exp = exp_q.pop_front();
          pos = 0;
          in_slot = 1'b1;
        end
      end
      if (in_slot) begin
        chk("dout_slot", {24'h0, dout}, {24'h0, cur_exp});
        pos++;
        if (pos == GAP) in_slot = 1'b0;
      end
      if (byte_available) ba_hi++;
      else if (ba_q) begin chk("ba_width", ba_hi, 2); ba_hi = 0; end
      if (ready_for_next_byte) begin rf_hi++; rfnb_total++; end
      else if (rf_q) begin chk("rfnb_width", rf_hi, GAP - 2); rf_hi = 0; end
      ba_q = byte_available;
      rf_q = ready_for_next_byte;
    end
  end

  initial begin
    #(95000 * 40);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 6000) begin @(negedge clk_in); n++; end
    chk(name, ready, 1);
  endtask

  // Called at a negedge with reset asserted; releases it and checks init timing.
  task automatic init_check();
    chk("rst_ready", ready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ba", byte_available, 0);
    chk("rst_rfnb", ready_for_next_byte, 0);
    chk("rst_err", err_out, 0);
    rst_n_in = 1'b1;
    err_m = 1'b0;
    for (int i = 0; i < INIT - 1; i++) begin
      @(negedge clk_in);
      chk("init_ready_low", ready, 0);
      chk("init_quiet", {byte_available, ready_for_next_byte, err_out}, 0);
    end
    @(negedge clk_in);
    chk("init_ready_high", ready, 1);
    chk("init_dout", dout, 0);
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] a);
    wait_ready("ready_before_cmd");
    address = a; rd = r; wr = w;
    @(negedge clk_in);
    chk("ready_drop", ready, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic both, input logic hold);
    logic [31:0] s = a >> 9;
    logic        o = (s >= NS);
    int          base_rx = rx_cnt;
    int          base_rf = rfnb_total;
    int          n = 0;
    for (int i = 0; i < SS; i++) exp_q.push_back(o ? 8'hFF : ram_m[s*SS + i]);
    if (o) err_m = 1'b1;
    issue(1'b1, both, a);
    wr = 1'b0;
    if (!hold) begin
      rd = 1'b0;
      wait_ready("read_done");
    end else begin
      while (rx_cnt - base_rx < SS && n < 6000) begin @(negedge clk_in); n++; end
      repeat (GAP + 2) @(negedge clk_in);
      for (int i = 0; i < 20; i++) begin
        chk("done_hold_ready", ready, 0);
        @(negedge clk_in);
      end
      rd = 1'b0;
      @(negedge clk_in);
      chk("done_release_ready", ready, 1);
    end
    chk("read_byte_count", rx_cnt - base_rx, SS);
    chk("read_queue_empty", exp_q.size(), 0);
    chk("err_after_read", err_out, err_m);
    if (both) chk("rfnb_during_rdwr", rfnb_total - base_rf, 0);
  endtask

  // Writes wbuf; if abort_at < SS, reset is asserted when byte abort_at is requested.
  task automatic do_write(input logic [31:0] a, input int abort_at);
    logic [31:0] s = a >> 9;
    logic        o = (s >= NS);
    logic        prev;
    int          n;
    if (o) err_m = 1'b1;
    issue(1'b0, 1'b1, a);
    wr = 1'b0;
    prev = ready_for_next_byte;
    for (int i = 0; i < SS; i++) begin
      n = 0;
      forever begin
        @(negedge clk_in);
        n++;
        if (ready_for_next_byte && !prev) break;
        prev = ready_for_next_byte;
        if (n > LAT + 2*GAP + 8) break;
      end
      if (!(ready_for_next_byte && !prev)) begin
        fail("write_byte_req", "timeout waiting for ready_for_next_byte");
        return;
      end
      prev = ready_for_next_byte;
      if (i == abort_at) begin
        #5 rst_n_in = 1'b0;
        #1;
        chk("abort_ready", ready, 0);
        chk("abort_rfnb", ready_for_next_byte, 0);
        chk("abort_ba", byte_available, 0);
        chk("abort_dout", dout, 0);
        chk("abort_err", err_out, 0);
        return;
      end
      din = wbuf[i];
      if (!o) ram_m[s*SS + i] = wbuf[i];
    end
    wait_ready("write_done");
    chk("err_after_write", err_out, err_m);
  endtask

  function automatic logic [31:0] lsb_noise();
    return 32'($urandom_range(0, SS - 1));
  endfunction

  initial begin
    logic [31:0] rs;
    repeat (3) @(negedge clk_in);
    init_check();

    // Incrementing pattern into sector 0, read it back.
    for (int i = 0; i < SS; i++) wbuf[i] = 8'(i);
    do_write(32'h0 | lsb_noise(), SS);
    do_read(32'h0, 1'b0, 1'b0);

    // Constant fill of sector 1 must not disturb sector 0.
    for (int i = 0; i < SS; i++) wbuf[i] = 8'hA5;
    do_write(32'h200, SS);
    do_read(32'h0 | lsb_noise(), 1'b0, 1'b0);
    do_read(32'h200, 1'b0, 1'b0);

    // Out-of-range sector 8: reads 0xFF, write discarded (it aliases sector 0).
    do_read(32'(8*SS), 1'b0, 1'b0);
    for (int i = 0; i < SS; i++) wbuf[i] = 8'($urandom);
    do_write(32'(8*SS) | lsb_noise(), SS);
    do_read(32'(8*SS), 1'b0, 1'b0);
    do_read(32'h0, 1'b0, 1'b0);

    // rd and wr together: read wins; rd held past the end keeps DONE.
    do_read(32'h200, 1'b1, 1'b1);

    // Random data into a random in-range sector.
    rs = 32'($urandom_range(2, NS - 1));
    for (int i = 0; i < SS; i++) wbuf[i] = 8'($urandom);
    do_write((rs << 9) | lsb_noise(), SS);
    do_read(rs << 9, 1'b0, 1'b0);

    // Reset in the middle of a write to sector 0 after byte 99 lands.
    for (int i = 0; i < SS; i++) wbuf[i] = 8'($urandom);
    do_write(32'h0, 100);
    repeat (2) @(negedge clk_in);
    init_check();
    do_read(32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
